// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares single-port data memory between the MEM stage (priority) and an external master with starvation bound and burst cap
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wd,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] W_MAX  = WW'(STARVE_LIMIT);
  localparam logic [BW-1:0] B_LAST = BW'(MAX_BURST - 1);
  typedef enum logic {S_CPU, S_EXT} owner_t;
  owner_t owner_q, owner_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [BW-1:0] burst_q, burst_d;
  logic rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic is_ext, go_ext, stay;
  always_comb begin
    is_ext   = owner_q == S_EXT;
    go_ext   = !is_ext && ext_req && (!cpu_req || wait_q == W_MAX);
    stay     = is_ext && ext_req && burst_q < B_LAST;
    owner_d  = (go_ext || stay) ? S_EXT : S_CPU;
    wait_d   = (is_ext || go_ext || !ext_req) ? '0 : (wait_q == W_MAX ? wait_q : wait_q + WW'(1));
    burst_d  = stay ? burst_q + BW'(1) : '0;
    rvalid_d = ext_gnt && ext_req && !ext_we;
    rdata_d  = rvalid_d ? mem_rd : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= S_CPU;
      wait_q   <= '0;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end
  // Reset forces every side effect off combinationally, even mid-burst
  assign ext_gnt    = !rst && is_ext;
  assign cpu_stall  = !rst && is_ext && cpu_req;
  assign mem_we     = !rst && (is_ext ? ext_req && ext_we : cpu_req && cpu_we);
  assign mem_addr   = is_ext ? ext_addr : cpu_addr;
  assign mem_wd     = is_ext ? ext_wd : cpu_wd;
  assign cpu_rd     = mem_rd;
  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with grant/read-data scoreboards checked by a negedge monitor
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wd, ext_addr, ext_wd;
  logic [31:0] cpu_rd, ext_rdata, mem_addr, mem_wd, mem_rd;
  logic cpu_stall, ext_gnt, ext_rvalid, mem_we;
  logic [31:0] mem [0:63] = '{default: 32'h0};
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  int exp_gnt_q[$];
  logic [31:0] exp_rd_q[$];
  logic gnt_prev = 1'b0;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected grant-start cycles and read data as the DUT presents them
  always @(negedge clk) begin
    if (ext_gnt && !gnt_prev) begin
      if (exp_gnt_q.size() == 0) chk("unexpected_grant_cycle", cyc, 32'hFFFF_FFFF);
      else chk("grant_start_cycle", cyc, exp_gnt_q.pop_front());
    end
    gnt_prev = ext_gnt;
    if (ext_rvalid) begin
      if (exp_rd_q.size() == 0) chk("unexpected_rvalid", ext_rdata, 32'hFFFF_FFFF);
      else chk("ext_rdata", ext_rdata, exp_rd_q.pop_front());
    end
  end

  initial begin
    int t;
    int rel;
    logic eg;
    // Test 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      {cpu_req, cpu_we, ext_req, ext_we} = 4'($urandom);
      cpu_addr = $urandom; cpu_wd = $urandom; ext_addr = $urandom; ext_wd = $urandom;
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_ext_gnt", 32'(ext_gnt), 0);
      chk("rst_cpu_stall", 32'(cpu_stall), 0);
      chk("rst_ext_rvalid", 32'(ext_rvalid), 0);
    end
    step();
    rst = 1'b0;
    {cpu_req, cpu_we, ext_req, ext_we} = 4'b0;
    cpu_addr = 32'h44; cpu_wd = 32'h0; ext_addr = 32'h0; ext_wd = 32'h0;
    @(negedge clk);
    chk("post_rst_gnt", 32'(ext_gnt), 0);
    chk("post_rst_owner_cpu_addr", mem_addr, 32'h44);
    // Test 2: idle CPU, EXT write then read
    step();
    t = cyc;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h10; ext_wd = 32'hDEADBEEF;
    exp_gnt_q.push_back(t + 1);
    step();
    @(negedge clk);
    chk("wr_gnt", 32'(ext_gnt), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_wd", mem_wd, 32'hDEADBEEF);
    step();
    ext_we = 1'b0;
    exp_rd_q.push_back(32'hDEADBEEF);
    step();
    ext_req = 1'b0;
    @(negedge clk);
    chk("idle_gnt_rvalid", 32'(ext_rvalid), 1);
    chk("idle_gnt_no_we", 32'(mem_we), 0);
    step();
    step();
    // Tests 3/4: CPU busy and EXT writes held for three grant periods
    t = cyc;
    cpu_req = 1'b1; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wd = 32'hA5A5_0000;
    exp_gnt_q.push_back(t + 5);
    exp_gnt_q.push_back(t + 18);
    exp_gnt_q.push_back(t + 31);
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      rel = cyc - t;
      eg = rel >= 5 && ((rel - 5) % 13) < 8;
      chk("starve_gnt", 32'(ext_gnt), 32'(eg));
      chk("starve_stall", 32'(cpu_stall), 32'(eg));
    end
    step();
    cpu_req = 1'b0; ext_req = 1'b0;
    step();
    step();
    // Test 5: simultaneous rise, CPU wins
    cpu_req = 1'b1; ext_req = 1'b1; ext_we = 1'b0;
    @(negedge clk);
    chk("tie_stall", 32'(cpu_stall), 0);
    chk("tie_gnt", 32'(ext_gnt), 0);
    step();
    @(negedge clk);
    chk("tie_next_gnt", 32'(ext_gnt), 0);
    chk("tie_next_stall", 32'(cpu_stall), 0);
    step();
    cpu_req = 1'b0; ext_req = 1'b0;
    step();
    // Test 6: reset in the third cycle of an EXT write burst
    t = cyc;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30; ext_wd = 32'h1111_1111;
    exp_gnt_q.push_back(t + 1);
    step();
    step();
    ext_addr = 32'h34; ext_wd = 32'h2222_2222;
    step();
    ext_addr = 32'h38; ext_wd = 32'h3333_3333; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_we", 32'(mem_we), 0);
    chk("mid_rst_gnt", 32'(ext_gnt), 0);
    step();
    rst = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    chk("after_rst_gnt", 32'(ext_gnt), 0);
    chk("after_rst_rvalid", 32'(ext_rvalid), 0);
    // Read back through EXT: 0x38 untouched, earlier writes present
    step();
    t = cyc;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h38;
    exp_gnt_q.push_back(t + 1);
    step();
    exp_rd_q.push_back(32'h0);
    step();
    ext_addr = 32'h20;
    exp_rd_q.push_back(32'hA5A5_0000);
    step();
    ext_addr = 32'h34;
    exp_rd_q.push_back(32'h2222_2222);
    step();
    ext_req = 1'b0;
    for (int i = 0; i < 10 && (exp_rd_q.size() != 0 || exp_gnt_q.size() != 0); i++) step();
    chk("pending_reads", 32'(exp_rd_q.size()), 0);
    chk("pending_grants", 32'(exp_gnt_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
